// File: rtl/xor5_parity_sched_if.sv
// rtl/xor5_parity_sched_if.sv - request/grant/result bundle shared by the parity scheduler and its clients
interface xor5_parity_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 20,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy;
    logic                      res_valid;
    logic                      res_parity;
    logic [ID_W-1:0]           res_id;
    logic                      res_ready;

    modport master (
        output req, data, res_ready,
        input  gnt, busy, res_valid, res_parity, res_id
    );

    modport slave (
        input  req, data, res_ready,
        output gnt, busy, res_valid, res_parity, res_id
    );
endinterface

// File: rtl/xor5_parity_sched.sv
// rtl/xor5_parity_sched.sv - round-robin sharing of one XOR5 parity datapath; XOR5_PARITY_SCHED_CNT_EN adds done_cnt
module xor5_parity_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 20,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    xor5_parity_sched_if.slave   bus
`ifdef XOR5_PARITY_SCHED_CNT_EN
    ,
    output logic [15:0]          done_cnt
`endif
);
    localparam int CHUNKS = DATA_W / 4;
    localparam int K_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_ptr, r_res_id, w_win;
    logic                w_found;
    logic [DATA_W-1:0]   r_word;
    logic [K_W-1:0]      r_k;
    logic                r_acc, w_acc_nxt, w_last;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_res_valid, r_res_parity;
    logic [3:0]          w_chunk;

    // First set request at or above the pointer, wrapping back to 0.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.req[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_win   = ID_W'((int'(r_ptr) + i) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_chunk   = r_word[{r_k, 2'b00} +: 4];
        w_acc_nxt = r_acc ^ (^w_chunk);
        w_last    = (r_k == K_W'(CHUNKS - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)       w_state_nxt = S_RUN;
            S_RUN:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.res_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_res_id     <= '0;
            r_word       <= '0;
            r_k          <= '0;
            r_acc        <= 1'b0;
            r_gnt        <= '0;
            r_res_valid  <= 1'b0;
            r_res_parity <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= NUM_REQ'(1) << w_win;
                        r_word   <= bus.data[int'(w_win)*DATA_W +: DATA_W];
                        r_res_id <= w_win;
                        r_acc    <= 1'b0;
                        r_k      <= '0;
                        r_ptr    <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_k   <= r_k + 1'b1;
                    if (w_last) begin
                        r_res_parity <= w_acc_nxt;
                        r_res_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) r_res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt        = r_gnt;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.res_valid  = r_res_valid;
    assign bus.res_parity = r_res_parity;
    assign bus.res_id     = r_res_id;

`ifdef XOR5_PARITY_SCHED_CNT_EN
    logic [15:0] r_done_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_cnt <= '0;
        end else if (r_state == S_DONE && bus.res_ready && r_done_cnt != 16'hFFFF) begin
            r_done_cnt <= r_done_cnt + 16'd1;
        end
    end

    assign done_cnt = r_done_cnt;
`endif
endmodule

// File: tb/tb_xor5_parity_sched.sv
// tb/tb_xor5_parity_sched.sv - randomized self-checking bench for xor5_parity_sched against a job-level model
module tb_xor5_parity_sched;
    localparam int N  = 4;
    localparam int DW = 20;
    localparam int IW = 2;
    localparam int CH = DW / 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xor5_parity_sched_if #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

`ifdef XOR5_PARITY_SCHED_CNT_EN
    logic [15:0] done_cnt;
`endif

    xor5_parity_sched #(.NUM_REQ(N), .DATA_W(DW), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef XOR5_PARITY_SCHED_CNT_EN
        ,
        .done_cnt (done_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'(bus.gnt), 0);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_valid"},  32'(bus.res_valid), 0);
        check({tag, "_parity"}, 32'(bus.res_parity), 0);
        check({tag, "_id"},     32'(bus.res_id), 0);
`ifdef XOR5_PARITY_SCHED_CNT_EN
        check({tag, "_cnt"},    32'(done_cnt), 0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        bus.req = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    // One complete job: arbitration, CHUNKS run cycles, bp stall cycles, acceptance.
    task automatic run_job(input logic [N-1:0] pat, input logic [N*DW-1:0] dat,
                           input logic [N-1:0] pend, input int bp);
        int win;
        logic [DW-1:0] word;
        int exp_par;
        bus.req  = pat;
        bus.data = dat;
        tick();
        if (pat == '0) begin
            check("idle_gnt",  32'(bus.gnt), 0);
            check("idle_busy", 32'(bus.busy), 0);
            return;
        end
        win = -1;
        for (int d = 0; d < N && win < 0; d++)
            if (pat[(m_ptr + d) % N]) win = (m_ptr + d) % N;
        word    = dat[win*DW +: DW];
        exp_par = $countones(word) % 2;
        m_ptr   = (win + 1) % N;
        check("gnt",  32'(bus.gnt), 32'(1) << win);
        check("busy", 32'(bus.busy), 1);
        bus.req = pend;
        for (int c = 1; c < CH; c++) begin
            tick();
            check("run_gnt",   32'(bus.gnt), 0);
            check("run_valid", 32'(bus.res_valid), 0);
        end
        tick();
        check("valid",  32'(bus.res_valid), 1);
        check("parity", 32'(bus.res_parity), 32'(exp_par));
        check("id",     32'(bus.res_id), 32'(win));
        for (int b = 0; b < bp; b++) begin
            tick();
            check("bp_valid",  32'(bus.res_valid), 1);
            check("bp_parity", 32'(bus.res_parity), 32'(exp_par));
            check("bp_id",     32'(bus.res_id), 32'(win));
            check("bp_gnt",    32'(bus.gnt), 0);
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        if (m_cnt < 65535) m_cnt++;
        check("acc_valid", 32'(bus.res_valid), 0);
        check("acc_busy",  32'(bus.busy), 0);
        check("acc_gnt",   32'(bus.gnt), 0);
`ifdef XOR5_PARITY_SCHED_CNT_EN
        check("done_cnt",  32'(done_cnt), 32'(m_cnt));
`endif
    endtask

    function automatic logic [N*DW-1:0] one_word(input int k, input logic [DW-1:0] w);
        logic [N*DW-1:0] v;
        v = '0;
        v[k*DW +: DW] = w;
        return v;
    endfunction

    initial begin
        logic [95:0] rnd;
        rst = 1'b1;
        bus.req = '1;
        bus.data = '0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all_zero("rst");
        end
        rst = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        bus.req = '0;
        tick();

        run_job(4'b0010, one_word(1, 20'h00001), 4'b0000, 0);
        run_job(4'b0001, one_word(0, 20'hFFFFF), 4'b0000, 0);
        run_job(4'b0001, one_word(0, 20'h80000), 4'b0000, 1);
        run_job(4'b0001, one_word(0, 20'h12345), 4'b0000, 0);

        do_reset(2);
        for (int j = 0; j < 5; j++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            run_job(4'b1111, rnd[N*DW-1:0], 4'b1111, 0);
        end
        rnd = {$urandom(), $urandom(), $urandom()};
        run_job(4'b1001, rnd[N*DW-1:0], 4'b0000, 0);

        rnd = {$urandom(), $urandom(), $urandom()};
        run_job(4'b0001, rnd[N*DW-1:0], 4'b0100, 10);
        run_job(4'b0100, rnd[N*DW-1:0], 4'b0000, 0);

        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrun");
        rst = 1'b0;
        m_ptr = 0;
        m_cnt = 0;
        rnd = {$urandom(), $urandom(), $urandom()};
        run_job(4'b0101, rnd[N*DW-1:0], 4'b0000, 0);

        for (int j = 0; j < 25; j++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            run_job(4'($urandom_range(0, 15)), rnd[N*DW-1:0],
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
